path_replayer: RTL and testbench
================================

PATH_REPLAYER -- requirements
Module: path_replayer

Interface
REQ-001 Parameter DISCARD_FIRST, default 1: when 1, the first entry popped after queue-mode switch is a sentinel slot and is dropped, not emitted.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin replay; ignored outside IDLE.
REQ-005 empStck  input  1  path-store empty flag, combinational from store, valid every cycle.
REQ-006 locIn  input  8  popped location from store, [7:4]=x, [3:0]=y; valid the cycle after pop.
REQ-007 done  output  1  one-cycle pulse to store: switch to queue (oldest-first) pop order.
REQ-008 pop  output  1  one-cycle pop request to store.
REQ-009 locOut  output  8  current emitted location.
REQ-010 dir  output  2  move from previous emitted location: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-011 first  output  1  high with the first emitted location; dir is 00 and meaningless then.
REQ-012 valid  output  1  locOut/dir/first/err valid.
REQ-013 ready  input  1  consumer accepts when valid&ready at a rising edge.
REQ-014 err  output  1  emitted location not 4-adjacent to previous (qualified by valid, not first).
REQ-015 count  output  8  number of locations accepted by consumer this replay, saturating at 255.
REQ-016 finished  output  1  high in FIN until next start.

Function
REQ-017 States: IDLE, ARM, SETTLE, CHECK, GRAB, OUT, FIN.
REQ-018 IDLE: start -> ARM; count cleared to 0 on that edge; first flag armed.
REQ-019 ARM: done=1 for exactly this cycle -> SETTLE.
REQ-020 SETTLE: no outputs to store -> CHECK (one cycle for store pointer update).
REQ-021 CHECK: if empStck=1 -> FIN with no pop; else pop=1 for this cycle only -> GRAB.
REQ-022 GRAB: sample locIn; if DISCARD_FIRST=1 and this is the first pop of the replay, discard it -> CHECK; else register locOut, compute dir/err against previous location -> OUT.
REQ-023 OUT: valid=1, outputs held stable until ready=1; on valid&ready: previous location <= locOut, first cleared, count incremented (saturating) -> CHECK.
REQ-024 FIN: finished=1; start -> ARM (new replay, count cleared, first armed).
REQ-025 pop and done are never high in the same cycle and never high outside CHECK/ARM respectively.
REQ-026 dir/err from dx = x_new - x_prev, dy = y_new - y_prev (4-bit unsigned, no wrap allowed): exactly one of |dx|,|dy| equal 1 and other 0 -> dir per REQ-010, err=0; otherwise dir=00, err=1.
REQ-027 Edge coordinates: x=0 to x=15 (or y) is not adjacent; err=1.
REQ-028 Repeated identical location: err=1, still emitted.
REQ-029 Minimum per-entry latency: CHECK->GRAB->OUT, valid asserts 2 cycles after pop; back-to-back throughput one location per 3 cycles with ready held high.
REQ-030 start while not IDLE/FIN ignored; ready while valid=0 ignored.
REQ-031 Empty store at first CHECK -> FIN with count=0, no valid ever asserted.

Reset
REQ-032 rst asserted at any time, including mid-OUT or mid-pop, forces IDLE immediately; done=0, pop=0, valid=0, first=0, err=0, finished=0, dir=00, locOut=8'h00, count=0, previous location=8'h00.
REQ-033 After rst deasserts, no store pulses until a new start.

Verification
REQ-034 Store entries 11,12,22 (sentinel first), ready=1, start -> done one pulse, outputs 11 first=1; 12 dir=10; 22 dir=01; finished=1, count=3.
REQ-035 Empty store, start -> done pulse, no pop, finished=1 next cycles, count=0, valid never 1.
REQ-036 ready held 0 for 5 cycles in OUT -> locOut/dir stable, no pop issued, count unchanged; ready=1 -> advances.
REQ-037 Sequence 33,35 and F0,00 -> err=1 dir=00 for 35 and for 00.
REQ-038 rst asserted during OUT with valid=1 -> all outputs at REQ-032 values same cycle; later start replays from store order.
REQ-039 DISCARD_FIRST=0, entries 44,34 -> both emitted, 34 dir=11.

Source files
------------

// File: rtl/path_replayer.sv
// Replays a stored path oldest-first: switches the store to queue order, pops
// entries one at a time and emits each location with its move direction.
module path_replayer #(
  parameter bit DISCARD_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       empStck,
  input  logic [7:0] locIn,
  output logic       done,
  output logic       pop,
  output logic [7:0] locOut,
  output logic [1:0] dir,
  output logic       first,
  output logic       valid,
  input  logic       ready,
  output logic       err,
  output logic [7:0] count,
  output logic       finished
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] GRAB   = 3'd4;
  localparam logic [2:0] OUT    = 3'd5;
  localparam logic [2:0] FIN    = 3'd6;

  logic [2:0] state;
  logic [7:0] prevLoc;
  logic       firstArm;
  logic       discardPend;
  logic       errReg;
  logic [1:0] dirNext;
  logic       errNext;
  logic [4:0] xN, yN, xP, yP;

  // 5-bit compares so 0<->15 never looks adjacent.
  always_comb begin
    xN      = {1'b0, locIn[7:4]};
    yN      = {1'b0, locIn[3:0]};
    xP      = {1'b0, prevLoc[7:4]};
    yP      = {1'b0, prevLoc[3:0]};
    dirNext = 2'b00;
    errNext = 1'b1;
    if (xN == xP && yN + 5'd1 == yP) begin
      dirNext = 2'b00; errNext = 1'b0;
    end else if (yN == yP && xN == xP + 5'd1) begin
      dirNext = 2'b01; errNext = 1'b0;
    end else if (xN == xP && yN == yP + 5'd1) begin
      dirNext = 2'b10; errNext = 1'b0;
    end else if (yN == yP && xN + 5'd1 == xP) begin
      dirNext = 2'b11; errNext = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prevLoc     <= 8'h00;
      locOut      <= 8'h00;
      dir         <= 2'b00;
      errReg      <= 1'b0;
      count       <= 8'h00;
      firstArm    <= 1'b0;
      discardPend <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: if (start) begin
          state       <= ARM;
          count       <= 8'h00;
          firstArm    <= 1'b1;
          discardPend <= DISCARD_FIRST;
        end
        ARM:    state <= SETTLE;
        SETTLE: state <= CHECK;
        CHECK:  state <= empStck ? FIN : GRAB;
        GRAB: begin
          if (discardPend) begin
            discardPend <= 1'b0;
            state       <= CHECK;
          end else begin
            locOut <= locIn;
            dir    <= firstArm ? 2'b00 : dirNext;
            errReg <= firstArm ? 1'b0 : errNext;
            state  <= OUT;
          end
        end
        OUT: if (ready) begin
          prevLoc  <= locOut;
          firstArm <= 1'b0;
          if (count != 8'hFF) count <= count + 8'd1;
          state    <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done     = (state == ARM);
  assign pop      = (state == CHECK) && !empStck;
  assign valid    = (state == OUT);
  assign first    = valid && firstArm;
  assign err      = valid && errReg;
  assign finished = (state == FIN);

endmodule

// File: tb/tb_path_replayer.sv
// Bench for path_replayer: store model, table vectors, hand sequences and
// random paths checked against an expected-emission list.
module tb_path_replayer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0, sel = 1'b0;
  logic empStck;
  logic [7:0] locIn = 8'h00;
  logic done0, pop0, first0, valid0, err0, fin0;
  logic done1, pop1, first1, valid1, err1, fin1;
  logic [7:0] locOut0, count0, locOut1, count1;
  logic [1:0] dir0, dir1;
  logic doneS, popS, firstS, validS, errS, finS;
  logic [7:0] locOutS, countS;
  logic [1:0] dirS;

  typedef struct packed {logic [7:0] loc; logic [1:0] dir; logic err; logic first;} em_t;
  typedef struct {logic [7:0] prev; logic [7:0] nxt; logic [1:0] dir; logic err;} vec_t;

  logic [7:0] mem[$];
  int memLen = 0, rdIdx = 0;
  em_t expQ[$];
  int nChecks = 0, nPass = 0;

  always #5 clk = ~clk;

  path_replayer #(.DISCARD_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .empStck(empStck), .locIn(locIn),
    .done(done0), .pop(pop0), .locOut(locOut0), .dir(dir0), .first(first0),
    .valid(valid0), .ready(ready), .err(err0), .count(count0), .finished(fin0));
  path_replayer #(.DISCARD_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start & sel), .empStck(empStck), .locIn(locIn),
    .done(done1), .pop(pop1), .locOut(locOut1), .dir(dir1), .first(first1),
    .valid(valid1), .ready(ready), .err(err1), .count(count1), .finished(fin1));

  assign doneS   = sel ? done1 : done0;
  assign popS    = sel ? pop1 : pop0;
  assign firstS  = sel ? first1 : first0;
  assign validS  = sel ? valid1 : valid0;
  assign errS    = sel ? err1 : err0;
  assign finS    = sel ? fin1 : fin0;
  assign locOutS = sel ? locOut1 : locOut0;
  assign countS  = sel ? count1 : count0;
  assign dirS    = sel ? dir1 : dir0;
  assign empStck = (rdIdx >= memLen);

  // Path store already in queue order; done rewinds to the oldest entry.
  always @(posedge clk) begin
    if (doneS) rdIdx <= 0;
    else if (popS && rdIdx < memLen) begin
      locIn <= mem[rdIdx];
      rdIdx <= rdIdx + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference: emission list straight from the adjacency rules.
  task automatic buildExp(input bit disc);
    int s;
    s = disc ? 1 : 0;
    expQ.delete();
    for (int k = s; k < mem.size(); k++) begin
      em_t e;
      int dx, dy;
      e.loc = mem[k]; e.first = (k == s); e.dir = 2'b00; e.err = 1'b0;
      if (!e.first) begin
        dx = int'(mem[k][7:4]) - int'(mem[k-1][7:4]);
        dy = int'(mem[k][3:0]) - int'(mem[k-1][3:0]);
        if      (dx == 0 && dy == -1) e.dir = 2'b00;
        else if (dx == 1 && dy == 0)  e.dir = 2'b01;
        else if (dx == 0 && dy == 1)  e.dir = 2'b10;
        else if (dx == -1 && dy == 0) e.dir = 2'b11;
        else e.err = 1'b1;
      end
      expQ.push_back(e);
    end
  endtask

  task automatic runReplay(input string tag, input bit doStart, input bit randReady,
                           input int budget, output int nValid);
    int acc, dones, popCyc;
    bit fin, lastValid;
    em_t e;
    acc = 0; dones = 0; popCyc = -100; fin = 0; nValid = 0;
    lastValid = validS;
    if (doStart) begin
      @(negedge clk); start = 1'b1;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      ready = randReady ? 1'($urandom % 2) : 1'b1;
      if (doneS) dones++;
      if (doneS && popS) chk({tag, " done&pop"}, 32'(1), 32'(0));
      if (popS) popCyc = c;
      if (validS && !lastValid && popCyc >= 0) chk({tag, " latency"}, 32'(c - popCyc), 32'(2));
      lastValid = validS;
      if (validS) begin
        nValid++;
        if (ready) begin
          if (expQ.size() == 0) chk({tag, " extra emit"}, 32'({locOutS}), 32'(0));
          else begin
            e = expQ.pop_front();
            chk({tag, " emit"}, 32'({locOutS, dirS, errS, firstS}), 32'(e));
          end
          acc++;
        end
      end
      if (finS) begin fin = 1; break; end
    end
    ready = 1'b0;
    chk({tag, " finished"}, 32'(fin), 32'(1));
    chk({tag, " done pulses"}, 32'(dones), 32'(doStart ? 1 : 0));
    chk({tag, " count"}, 32'(countS), 32'(acc > 255 ? 255 : acc));
    chk({tag, " missing emits"}, 32'(expQ.size()), 32'(0));
  endtask

  task automatic waitValid(input string tag);
    bit seen;
    seen = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); start = 1'b0;
      if (validS) begin seen = 1; break; end
    end
    chk({tag, " valid seen"}, 32'(seen), 32'(1));
  endtask

  vec_t vt[10];
  int nv;
  logic [7:0] lo;
  logic [1:0] dd;
  int x, y;

  initial begin
    vt[0] = '{8'h11, 8'h12, 2'b10, 1'b0};
    vt[1] = '{8'h11, 8'h21, 2'b01, 1'b0};
    vt[2] = '{8'h12, 8'h11, 2'b00, 1'b0};
    vt[3] = '{8'h21, 8'h11, 2'b11, 1'b0};
    vt[4] = '{8'h33, 8'h35, 2'b00, 1'b1};
    vt[5] = '{8'hF0, 8'h00, 2'b00, 1'b1};
    vt[6] = '{8'h0F, 8'h00, 2'b00, 1'b1};
    vt[7] = '{8'h55, 8'h55, 2'b00, 1'b1};
    vt[8] = '{8'h55, 8'h66, 2'b00, 1'b1};
    vt[9] = '{8'hEF, 8'hFF, 2'b01, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset outputs u0", 32'({done0, pop0, valid0, first0, err0, fin0, dir0, locOut0, count0}), 32'(0));
    chk("reset outputs u1", 32'({done1, pop1, valid1, first1, err1, fin1, dir1, locOut1, count1}), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle no pulses", 32'({done0, pop0, done1, pop1}), 32'(0));

    // Basic path with sentinel.
    mem = {8'h00, 8'h11, 8'h12, 8'h22}; memLen = mem.size();
    expQ.delete();
    expQ.push_back('{8'h11, 2'b00, 1'b0, 1'b1});
    expQ.push_back('{8'h12, 2'b10, 1'b0, 1'b0});
    expQ.push_back('{8'h22, 2'b01, 1'b0, 1'b0});
    runReplay("basic", 1, 0, 60, nv);

    // Table of adjacency vectors.
    foreach (vt[i]) begin
      mem = {8'hAA, vt[i].prev, vt[i].nxt}; memLen = mem.size();
      expQ.delete();
      expQ.push_back('{vt[i].prev, 2'b00, 1'b0, 1'b1});
      expQ.push_back('{vt[i].nxt, vt[i].dir, vt[i].err, 1'b0});
      runReplay($sformatf("vec%0d", i), 1, 0, 60, nv);
    end

    // Empty store.
    mem.delete(); memLen = 0; expQ.delete();
    runReplay("empty", 1, 0, 30, nv);
    chk("empty valid never", 32'(nv), 32'(0));

    // Consumer stall.
    mem = {8'h00, 8'h11, 8'h12}; memLen = mem.size();
    buildExp(1);
    ready = 1'b0;
    waitValid("stall");
    lo = locOutS; dd = dirS;
    repeat (5) begin
      @(negedge clk);
      chk("stall hold", 32'({validS, locOutS, dirS}), 32'({1'b1, lo, dd}));
      chk("stall no pop", 32'({popS, countS}), 32'(0));
    end
    runReplay("stall drain", 0, 0, 60, nv);

    // Reset during OUT.
    mem = {8'h00, 8'h11, 8'h12, 8'h22}; memLen = mem.size();
    waitValid("rstmid");
    rst = 1'b1; #1;
    chk("rstmid outputs", 32'({done0, pop0, valid0, first0, err0, fin0, dir0, locOut0, count0}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid quiet", 32'({doneS, popS}), 32'(0));
    end
    buildExp(1);
    runReplay("rstmid replay", 1, 0, 60, nv);

    // No sentinel variant.
    sel = 1'b1;
    mem = {8'h44, 8'h34}; memLen = mem.size();
    expQ.delete();
    expQ.push_back('{8'h44, 2'b00, 1'b0, 1'b1});
    expQ.push_back('{8'h34, 2'b11, 1'b0, 1'b0});
    runReplay("nodiscard", 1, 0, 40, nv);
    sel = 1'b0;

    // Count saturation.
    mem.delete();
    for (int k = 0; k < 261; k++) mem.push_back(k[0] ? 8'h11 : 8'h12);
    memLen = mem.size();
    buildExp(1);
    runReplay("saturate", 1, 0, 1000, nv);

    // Random walks, random ready, both variants.
    for (int r = 0; r < 24; r++) begin
      sel = 1'(r % 2);
      mem.delete();
      x = $urandom % 16; y = $urandom % 16;
      for (int k = 0; k < int'($urandom % 8); k++) begin
        if ($urandom % 4 == 0) begin x = $urandom % 16; y = $urandom % 16; end
        else case ($urandom % 4)
          0: if (y > 0) y--;
          1: if (x < 15) x++;
          2: if (y < 15) y++;
          default: if (x > 0) x--;
        endcase
        mem.push_back({4'(x), 4'(y)});
      end
      memLen = mem.size();
      buildExp(!sel);
      runReplay($sformatf("rand%0d", r), 1, 1, 400, nv);
    end
    sel = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
